// File: rtl/pkg_mostrador.sv
// Shared constants for the scanned 7-segment display driver:
// active-low segment patterns {g,f,e,d,c,b,a}, anode constants and
// the 2-bit profile encoding.
package pkg_mostrador;

  localparam logic [6:0] SEG_0       = 7'b1000000;
  localparam logic [6:0] SEG_1       = 7'b1111001;
  localparam logic [6:0] SEG_2       = 7'b0100100;
  localparam logic [6:0] SEG_3       = 7'b0110000;
  localparam logic [6:0] SEG_4       = 7'b0011001;
  localparam logic [6:0] SEG_5       = 7'b0010010;
  localparam logic [6:0] SEG_6       = 7'b0000010;
  localparam logic [6:0] SEG_7       = 7'b1111000;
  localparam logic [6:0] SEG_8       = 7'b0000000;
  localparam logic [6:0] SEG_9       = 7'b0010000;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  localparam logic [3:0] ANODOS_OFF  = 4'b1111;

  localparam logic [1:0] PERFIL_0 = 2'd0;
  localparam logic [1:0] PERFIL_1 = 2'd1;
  localparam logic [1:0] PERFIL_2 = 2'd2;
  localparam logic [1:0] PERFIL_3 = 2'd3;

  // Active-low enable for a single digit position.
  function automatic logic [3:0] anodo_digito(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not valid BCD and show a dash.
module decodificador_7seg
  import pkg_mostrador::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_segmentos
);

  // Lookup of the segment pattern for one nibble.
  always_comb begin
    o_segmentos = SEG_TRACO;
    case (i_bcd)
      4'd0:    o_segmentos = SEG_0;
      4'd1:    o_segmentos = SEG_1;
      4'd2:    o_segmentos = SEG_2;
      4'd3:    o_segmentos = SEG_3;
      4'd4:    o_segmentos = SEG_4;
      4'd5:    o_segmentos = SEG_5;
      4'd6:    o_segmentos = SEG_6;
      4'd7:    o_segmentos = SEG_7;
      4'd8:    o_segmentos = SEG_8;
      4'd9:    o_segmentos = SEG_9;
      default: o_segmentos = SEG_TRACO;
    endcase
  end

endmodule

// File: rtl/controle_mostrador_varredura.sv
// Time-multiplexed 4-digit common-anode display driver.
// Picks one of four BCD sources by the profile-select bits and scans its
// digits; the shown profile only changes at frame boundaries so a frame
// never mixes two sources. Each digit slot starts with one blank cycle to
// avoid ghosting. All outputs are registered.
// Optional build macro: MOSTRADOR_PISCA_EN adds the pisca input and a
// 6-bit frame counter that blanks the display during frames 32..63.
module controle_mostrador_varredura
  import pkg_mostrador::*;
#(
  parameter int DIV_VARREDURA = 50000
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        bits_mostrador,
  input  logic        bits_mostrador1,
  input  logic [15:0] dados_perfil0,
  input  logic [15:0] dados_perfil1,
  input  logic [15:0] dados_perfil2,
  input  logic [15:0] dados_perfil3,
`ifdef MOSTRADOR_PISCA_EN
  input  logic        pisca,
`endif
  output logic [6:0]  segmentos,
  output logic [3:0]  anodos,
  output logic [1:0]  perfil_ativo
);

  localparam int PW = (DIV_VARREDURA > 2) ? $clog2(DIV_VARREDURA) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_VARREDURA - 1);
  localparam logic [PW-1:0] PRESC_UM  = PW'(1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [1:0]    r_perfil_ativo;
  logic [6:0]    r_segmentos;
  logic [3:0]    r_anodos;

  logic [1:0]    w_sel_req;
  logic          w_tick;
  logic          w_fim_quadro;
  logic          w_inicio_slot;
  logic [15:0]   w_dados_sel;
  logic [3:0]    w_nibble;
  logic [6:0]    w_segmentos;
  logic [3:0]    w_anodos;

  assign w_sel_req     = {bits_mostrador1, bits_mostrador};
  assign w_tick        = (r_presc == PRESC_MAX);
  assign w_fim_quadro  = w_tick && (r_idx == 2'd3);
  assign w_inicio_slot = (r_presc == '0);

  // Prescaler and digit index: one slot per DIV_VARREDURA cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + PRESC_UM;
    end
  end

  // Profile register: a request is taken only on the last tick of a frame,
  // so short request glitches in between are never shown.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perfil_ativo <= PERFIL_0;
    end else if (w_fim_quadro) begin
      r_perfil_ativo <= w_sel_req;
    end
  end

  // Source word of the profile being shown (sources are not latched).
  always_comb begin
    w_dados_sel = dados_perfil0;
    case (r_perfil_ativo)
      PERFIL_0: w_dados_sel = dados_perfil0;
      PERFIL_1: w_dados_sel = dados_perfil1;
      PERFIL_2: w_dados_sel = dados_perfil2;
      PERFIL_3: w_dados_sel = dados_perfil3;
      default:  w_dados_sel = dados_perfil0;
    endcase
  end

  assign w_nibble = w_dados_sel[{r_idx, 2'b00} +: 4];

  decodificador_7seg u_decodificador (
    .i_bcd       (w_nibble),
    .o_segmentos (w_segmentos)
  );

`ifdef MOSTRADOR_PISCA_EN
  logic [5:0] r_quadros;

  // Frame counter driving the blink phase; wraps naturally after 63.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_quadros <= 6'd0;
    end else if (w_fim_quadro) begin
      r_quadros <= r_quadros + 6'd1;
    end
  end

  // Next anode value: blank at slot start, blank during the blink-off phase.
  always_comb begin
    w_anodos = anodo_digito(r_idx);
    if (w_inicio_slot || (pisca && r_quadros[5])) begin
      w_anodos = ANODOS_OFF;
    end
  end
`else
  // Next anode value: blank at slot start, otherwise the current digit.
  always_comb begin
    w_anodos = anodo_digito(r_idx);
    if (w_inicio_slot) begin
      w_anodos = ANODOS_OFF;
    end
  end
`endif

  // Output registers, one cycle behind the scan state they derive from.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_segmentos <= SEG_APAGADO;
      r_anodos    <= ANODOS_OFF;
    end else begin
      r_segmentos <= w_segmentos;
      r_anodos    <= w_anodos;
    end
  end

  assign segmentos    = r_segmentos;
  assign anodos       = r_anodos;
  assign perfil_ativo = r_perfil_ativo;

endmodule

// File: tb/tb_controle_mostrador_varredura.sv
// Bench for the scanned display driver with DIV_VARREDURA = 4.
// The reference model derives the scan position from the number of cycles
// since reset release and samples the profile request at frame ends.
module tb_controle_mostrador_varredura;

  localparam int DIV    = 4;
  localparam int QUADRO = 4 * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bits_mostrador = 1'b0;
  logic        bits_mostrador1 = 1'b0;
  logic [15:0] dados [4];
`ifdef MOSTRADOR_PISCA_EN
  logic        pisca = 1'b0;
`endif
  logic [6:0]  segmentos;
  logic [3:0]  anodos;
  logic [1:0]  perfil_ativo;

  always #5 clock = ~clock;

  controle_mostrador_varredura #(.DIV_VARREDURA(DIV)) dut (
    .clock           (clock),
    .reset           (reset),
    .bits_mostrador  (bits_mostrador),
    .bits_mostrador1 (bits_mostrador1),
    .dados_perfil0   (dados[0]),
    .dados_perfil1   (dados[1]),
    .dados_perfil2   (dados[2]),
    .dados_perfil3   (dados[3]),
`ifdef MOSTRADOR_PISCA_EN
    .pisca           (pisca),
`endif
    .segmentos       (segmentos),
    .anodos          (anodos),
    .perfil_ativo    (perfil_ativo)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int          t;          // cycles since reset release
  logic [1:0]  m_perfil;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic [1:0]  exp_perf;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Advance one clock; predicts what the outputs show after this edge.
  task automatic step();
    int p, d, q;
    logic [15:0] w;
    logic [3:0] nib;
    p = t % DIV;
    d = (t / DIV) % 4;
    q = (t / QUADRO) % 64;
    w = dados[m_perfil];
    nib = 4'(w >> (4 * d));
    exp_seg = ref_seg(nib);
    exp_an = (p == 0) ? 4'hF : (4'hF ^ 4'(1 << d));
`ifdef MOSTRADOR_PISCA_EN
    if (pisca && q >= 32) exp_an = 4'hF;
`else
    if (q < 0) exp_an = 4'hF;
`endif
    if (t % QUADRO == QUADRO - 1) m_perfil = {bits_mostrador1, bits_mostrador};
    exp_perf = m_perfil;
    t++;
    @(posedge clock);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    bits_mostrador1 = s[1];
    bits_mostrador  = s[0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    t = 0;
    m_perfil = 2'd0;
  endtask

  task automatic test_reset();
    set_sel(2'b11);
    do_reset();
    n_cmp++; if (anodos !== 4'b1111) begin n_err++; $display("FAIL reset_an got=%b exp=1111", anodos); end
    n_cmp++; if (segmentos !== 7'b1111111) begin n_err++; $display("FAIL reset_seg got=%b exp=1111111", segmentos); end
    n_cmp++; if (perfil_ativo !== 2'b00) begin n_err++; $display("FAIL reset_perf got=%b exp=00", perfil_ativo); end
  endtask

  task automatic test_scan();
    dados[0] = 16'h1234;
    set_sel(2'b00);
    do_reset();
    for (int i = 0; i < 2 * QUADRO; i++) begin
      step();
      n_cmp++; if (anodos !== exp_an) begin n_err++; $display("FAIL scan_an t=%0d got=%b exp=%b", t, anodos, exp_an); end
      n_cmp++; if (segmentos !== exp_seg) begin n_err++; $display("FAIL scan_seg t=%0d got=%b exp=%b", t, segmentos, exp_seg); end
      if (t == 2) begin
        n_cmp++; if (anodos !== 4'b1110) begin n_err++; $display("FAIL first_digit_an got=%b exp=1110", anodos); end
        n_cmp++; if (segmentos !== 7'b0011001) begin n_err++; $display("FAIL first_digit_seg got=%b exp=0011001", segmentos); end
      end
      if (t == DIV + 1) begin
        n_cmp++; if (anodos !== 4'b1111) begin n_err++; $display("FAIL slot_blank got=%b exp=1111", anodos); end
      end
      if (t == 3 * DIV + 2) begin
        n_cmp++; if (anodos !== 4'b0111 || segmentos !== 7'b1111001) begin
          n_err++; $display("FAIL digit3 got=%b/%b exp=0111/1111001", anodos, segmentos);
        end
      end
    end
  endtask

  task automatic test_profile_switch();
    dados[0] = 16'h1234;
    dados[2] = 16'h9999;
    set_sel(2'b00);
    do_reset();
    for (int i = 0; i < 6; i++) step();
    set_sel(2'b10);
    while (t < QUADRO) begin
      step();
      n_cmp++; if (perfil_ativo !== exp_perf) begin n_err++; $display("FAIL switch_perf t=%0d got=%b exp=%b", t, perfil_ativo, exp_perf); end
    end
    n_cmp++; if (perfil_ativo !== 2'b10) begin n_err++; $display("FAIL switch_done got=%b exp=10", perfil_ativo); end
    for (int i = 0; i < QUADRO; i++) begin
      step();
      n_cmp++; if (anodos !== exp_an) begin n_err++; $display("FAIL switch_an t=%0d got=%b exp=%b", t, anodos, exp_an); end
      n_cmp++; if (segmentos !== exp_seg) begin n_err++; $display("FAIL switch_seg t=%0d got=%b exp=%b", t, segmentos, exp_seg); end
      if (exp_an != 4'hF) begin
        n_cmp++; if (segmentos !== 7'b0010000) begin n_err++; $display("FAIL switch_nine t=%0d got=%b exp=0010000", t, segmentos); end
      end
    end
  endtask

  task automatic test_glitch();
    dados[0] = 16'h1234;
    dados[1] = 16'h5555;
    set_sel(2'b00);
    do_reset();
    step(); step();
    set_sel(2'b01);
    step(); step(); step();
    set_sel(2'b00);
    for (int i = 0; i < 2 * QUADRO; i++) begin
      step();
      n_cmp++; if (perfil_ativo !== 2'b00) begin n_err++; $display("FAIL glitch_perf t=%0d got=%b exp=00", t, perfil_ativo); end
      n_cmp++; if (segmentos !== exp_seg) begin n_err++; $display("FAIL glitch_seg t=%0d got=%b exp=%b", t, segmentos, exp_seg); end
    end
  endtask

  task automatic test_dash();
    dados[0] = 16'h0000;
    dados[1] = 16'hABCF;
    set_sel(2'b01);
    do_reset();
    for (int i = 0; i < 2 * QUADRO + 1; i++) begin
      step();
      n_cmp++; if (anodos !== exp_an) begin n_err++; $display("FAIL dash_an t=%0d got=%b exp=%b", t, anodos, exp_an); end
      n_cmp++; if (segmentos !== exp_seg) begin n_err++; $display("FAIL dash_seg t=%0d got=%b exp=%b", t, segmentos, exp_seg); end
      if (t > QUADRO + 1) begin
        n_cmp++; if (segmentos !== 7'b0111111) begin n_err++; $display("FAIL dash_pattern t=%0d got=%b exp=0111111", t, segmentos); end
      end
    end
  endtask

  task automatic test_reset_mid();
    dados[0] = 16'h1234;
    dados[3] = 16'h7777;
    set_sel(2'b00);
    do_reset();
    while (t < 2 * DIV + 2) step();
    set_sel(2'b11);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++; if (anodos !== 4'b1111) begin n_err++; $display("FAIL midreset_an got=%b exp=1111", anodos); end
    n_cmp++; if (segmentos !== 7'b1111111) begin n_err++; $display("FAIL midreset_seg got=%b exp=1111111", segmentos); end
    n_cmp++; if (perfil_ativo !== 2'b00) begin n_err++; $display("FAIL midreset_perf got=%b exp=00", perfil_ativo); end
    reset = 1'b0;
    t = 0;
    m_perfil = 2'd0;
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      n_cmp++; if (anodos !== exp_an) begin n_err++; $display("FAIL midreset_scan_an t=%0d got=%b exp=%b", t, anodos, exp_an); end
      n_cmp++; if (segmentos !== exp_seg) begin n_err++; $display("FAIL midreset_scan_seg t=%0d got=%b exp=%b", t, segmentos, exp_seg); end
      if (t == 2) begin
        n_cmp++; if (anodos !== 4'b1110) begin n_err++; $display("FAIL midreset_restart got=%b exp=1110", anodos); end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) dados[k] = 16'($urandom);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_sel(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) dados[$urandom_range(0, 3)] = 16'($urandom);
      step();
      n_cmp++; if (perfil_ativo !== exp_perf) begin n_err++; $display("FAIL rand_perf t=%0d got=%b exp=%b", t, perfil_ativo, exp_perf); end
      n_cmp++; if (anodos !== exp_an) begin n_err++; $display("FAIL rand_an t=%0d got=%b exp=%b", t, anodos, exp_an); end
      n_cmp++; if (segmentos !== exp_seg) begin n_err++; $display("FAIL rand_seg t=%0d got=%b exp=%b", t, segmentos, exp_seg); end
    end
  endtask

`ifdef MOSTRADOR_PISCA_EN
  task automatic test_pisca();
    int q;
    dados[0] = 16'h4321;
    set_sel(2'b00);
    pisca = 1'b1;
    do_reset();
    for (int i = 0; i < 65 * QUADRO; i++) begin
      step();
      q = ((t - 1) / QUADRO) % 64;
      n_cmp++; if (anodos !== exp_an) begin n_err++; $display("FAIL pisca_an t=%0d got=%b exp=%b", t, anodos, exp_an); end
      if (q >= 32) begin
        n_cmp++; if (anodos !== 4'b1111) begin n_err++; $display("FAIL pisca_off t=%0d got=%b exp=1111", t, anodos); end
      end
    end
    pisca = 1'b0;
    do_reset();
    for (int i = 0; i < 64 * QUADRO; i++) begin
      step();
      n_cmp++; if (anodos !== exp_an) begin n_err++; $display("FAIL pisca0_an t=%0d got=%b exp=%b", t, anodos, exp_an); end
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 4; k++) dados[k] = 16'h0000;
    t = 0;
    m_perfil = 2'd0;
    test_reset();
    test_scan();
    test_profile_switch();
    test_glitch();
    test_dash();
    test_reset_mid();
    test_random();
`ifdef MOSTRADOR_PISCA_EN
    test_pisca();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controle_mostrador_varredura.md
# controle_mostrador_varredura

Time-multiplexed 4-digit 7-segment display driver sitting directly downstream of the profile-select decoder. Takes the two profile-select bits (`bits_mostrador`, `bits_mostrador1`), picks one of four 16-bit BCD sources, and scans the digits onto a common-anode display. Profile changes take effect only at frame boundaries, so a frame never mixes digits from two interfaces.

## Interface
- `DIV_VARREDURA`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `bits_mostrador` in 1: profile select bit 0, from the upstream decoder.
- `bits_mostrador1` in 1: profile select bit 1, from the upstream decoder.
- `dados_perfil0` … `dados_perfil3` in 16 each: 4 BCD nibbles per profile; nibble 0 = `[3:0]` = rightmost digit.
- `pisca` in 1: blink request; present only with `MOSTRADOR_PISCA_EN`.
- `segmentos` out 7: active-low `{g,f,e,d,c,b,a}`.
- `anodos` out 4: active-low digit enables; bit i = digit i.
- `perfil_ativo` out 2: profile currently shown.

## Operation
- Profile request `sel_req = {bits_mostrador1, bits_mostrador}`, sampled each cycle.
- Prescaler counts 0 … DIV_VARREDURA-1. Tick is asserted in the cycle where the count equals DIV_VARREDURA-1; the count then wraps to 0.
- Digit index (2 bits) advances 0→1→2→3→0 on each tick.
- Frame boundary: a tick while the index = 3. On that edge, `perfil_ativo` <= `sel_req`. A request that toggles and reverts mid-frame is never shown.
- Data path: the nibble `dados_perfil[perfil_ativo][4*idx+3 : 4*idx]` is decoded to segments.
  - 0–9: standard patterns. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - 10–15: dash, 7'b0111111.
- Anti-ghosting:
  - In the first cycle after each tick, `anodos` = 4'b1111.
  - From the second cycle of the slot onward, `anodos` = ~(1<<idx).
- Source data are not latched. A change on `dados_perfilN` is visible on the next registered update.

## Timing
- All outputs are registered. Segment and anode updates occur one cycle after the prescaler/index state they derive from.
- Reset values:
  - prescaler 0, idx 0, `perfil_ativo` 2'b00.
  - `anodos` 4'b1111, `segmentos` 7'b1111111.
  - blink counter 0.
- First digit is lit 2 cycles after reset deasserts: digit 0, profile 0.
- Slot length is DIV_VARREDURA cycles: 1 blank cycle, then DIV_VARREDURA-1 lit cycles.
- Frame = 4·DIV_VARREDURA cycles.
- Worst-case profile change latency: 4·DIV_VARREDURA + 2 cycles from the `sel_req` change to the new data on the segments.
- Reset mid-scan: everything returns to the reset values on the next edge. Any pending profile change is discarded.

## Configuration
- `MOSTRADOR_PISCA_EN` defined:
  - Adds the `pisca` input and a 6-bit frame counter, incremented at each frame boundary and wrapping at 63.
  - While `pisca` = 1 and counter bit 5 = 1: `anodos` forced to 4'b1111. Scanning and counters continue.
  - `pisca` = 0: no effect.
- `MOSTRADOR_PISCA_EN` undefined:
  - No `pisca` port and no frame counter.
  - Display is always lit per normal scan.

## Structure
- Package `pkg_mostrador`:
  - segment constants `SEG_0` … `SEG_9`, `SEG_TRACO`, `SEG_APAGADO`.
  - `ANODOS_OFF` = 4'b1111.
  - 2-bit profile encoding constants `PERFIL_0` … `PERFIL_3`.
- Sub-module `decodificador_7seg`: combinational, 4-bit BCD in, 7-bit active-low segments out, using the package constants.
- Top module holds the prescaler, index, profile register, output registers and the optional blink counter.

## Test plan
All cases use DIV_VARREDURA = 4.
- Reset release, sel = 00, `dados_perfil0` = 16'h1234:
  - cycle 2: `anodos` = 4'b1110, `segmentos` = SEG_4.
  - next slots show 3, 2, 1 on anodes 1101, 1011, 0111.
  - one blank cycle (1111) at each slot start.
- Set sel = 10 at mid-frame, `dados_perfil2` = 16'h9999:
  - `perfil_ativo` stays 00 until the index-3 tick, then becomes 10.
  - the next frame shows 9 on all digits.
- Pulse sel = 01 for 3 cycles within one frame, then back to 00: `perfil_ativo` never leaves 00.
- `dados_perfil1` = 16'hABCF, sel = 01: all four digits show 7'b0111111.
- Assert reset during the digit-2 slot: next cycle `anodos` = 1111, `segmentos` = 1111111, `perfil_ativo` = 00. Scan restarts at digit 0.
- With `MOSTRADOR_PISCA_EN` and `pisca` = 1:
  - `anodos` stay 1111 for frames 32–63.
  - normal scan for frames 0–31.
  - with `pisca` = 0: normal scan in all frames.
